adc_sample_controller: RTL

- Sequences the serial 12-bit audio ADC of the equalizer front end at a fixed sample rate.
- Generates the ADC chip-select and serial clock, shifts in one 16-bit frame per sample period and presents each sample with a one-cycle valid strobe to the filter bank.
- Replaces free-running ADC clocking with a controlled conversion schedule: sample tick, then frame, then quiet time.

---
 rtl/adc_sample_controller.sv | 215 +++++++++++++++++++++
 1 files changed

// File: rtl/adc_sample_controller.sv
// adc_sample_controller
//   Drives a serial 12-bit ADC on a fixed conversion schedule. Each sample
//   period runs in three steps:
//     1. a sample tick,
//     2. a 16-bit frame clocked MSB first,
//     3. a quiet gap.
//   Each captured sample is presented to the filter bank with a one-cycle
//   valid strobe.
//
//   Parameters
//     CLK_DIV    : sclk half-period in clk cycles (>= 1)
//     SAMPLE_DIV : clk cycles per sample period (>= 34*CLK_DIV+4)
//     CNT_W      : width of the sample-period counter
//
//   Ports
//     clk          in   system clock
//     reset        in   asynchronous active-high reset
//     enable       in   1 = schedule conversions, 0 = stop after current frame
//     sdata        in   ADC serial data, MSB first
//     cs_n         out  ADC chip select, active low
//     sclk         out  ADC serial clock, idles high
//     sample[11:0] out  last captured sample, held until next valid
//     sample_valid out  one-cycle strobe, sample updated
//     frame_err    out  one-cycle strobe with sample_valid if frame[15:12] != 0
//     missed_tick  out  one-cycle strobe when a tick arrives outside IDLE
//     busy         out  high during CONV and QUIET
//
//   Build option
//     ADC_SIGNED_EN : when defined, the offset-binary code is converted to
//                     two's complement (code XOR 12'h800).
module adc_sample_controller #(
  parameter int CLK_DIV    = 2,
  parameter int SAMPLE_DIV = 2268,
  parameter int CNT_W      = 12
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        sdata,
  output logic        cs_n,
  output logic        sclk,
  output logic [11:0] sample,
  output logic        sample_valid,
  output logic        frame_err,
  output logic        missed_tick,
  output logic        busy
);

  localparam int DIV_W = $clog2(2 * CLK_DIV + 1);
  localparam logic [DIV_W-1:0] HALF_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] QUIET_LAST = DIV_W'(2 * CLK_DIV - 1);
  localparam logic [CNT_W-1:0] TICK_CNT   = CNT_W'(SAMPLE_DIV - 1);

  typedef enum logic [1:0] {S_IDLE, S_CONV, S_QUIET} state_t;

  function automatic logic [11:0] to_sample(input logic [11:0] code);
`ifdef ADC_SIGNED_EN
    return code ^ 12'h800;
`else
    return code;
`endif
  endfunction

  state_t           r_state;
  logic [CNT_W-1:0] r_period;
  logic [DIV_W-1:0] r_div;
  logic [3:0]       r_bits;
  logic             r_sclk;
  logic             r_sclk_d;
  logic             r_cs_n;
  logic             r_busy;
  logic [11:0]      r_sample;
  logic             r_valid;
  logic             r_ferr;
  logic             r_missed;
  logic [14:0]      r_shift;

  state_t           w_state_nxt;
  logic [DIV_W-1:0] w_div_nxt;
  logic [3:0]       w_bits_nxt;
  logic             w_sclk_nxt;
  logic             w_cs_n_nxt;
  logic             w_busy_nxt;
  logic [11:0]      w_sample_nxt;
  logic             w_valid_nxt;
  logic             w_ferr_nxt;
  logic             w_missed_nxt;
  logic             w_tick;
  logic             w_rise;
  logic             w_capture;
  logic [15:0]      w_frame;

  // Tick is gated by enable so a period counter caught at its terminal
  // value on the cycle enable drops cannot start a new frame.
  assign w_tick    = enable && (r_period == TICK_CNT);
  // Capture on the cycle in which the registered sclk has just risen.
  assign w_rise    = r_sclk && !r_sclk_d;
  assign w_capture = (r_state == S_CONV) && w_rise;
  assign w_frame   = {r_shift, sdata};

  // ---- sample-period counter ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_period <= '0;
    end else if (!enable || w_tick) begin
      r_period <= '0;
    end else begin
      r_period <= r_period + 1'b1;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_div_nxt    = r_div;
    w_bits_nxt   = r_bits;
    w_sclk_nxt   = r_sclk;
    w_cs_n_nxt   = r_cs_n;
    w_busy_nxt   = r_busy;
    w_sample_nxt = r_sample;
    w_valid_nxt  = 1'b0;
    w_ferr_nxt   = 1'b0;
    w_missed_nxt = w_tick && (r_state != S_IDLE);
    case (r_state)
      S_IDLE: begin
        if (w_tick) begin
          w_state_nxt = S_CONV;
          w_cs_n_nxt  = 1'b0;
          w_busy_nxt  = 1'b1;
          w_div_nxt   = '0;
          w_bits_nxt  = '0;
          w_sclk_nxt  = 1'b1;
        end
      end
      S_CONV: begin
        if (r_div == HALF_LAST) begin
          w_sclk_nxt = !r_sclk;
          w_div_nxt  = '0;
        end else begin
          w_div_nxt = r_div + 1'b1;
        end
        if (w_rise) begin
          if (r_bits == 4'd15) begin
            // Last bit arrives on sdata this cycle, so build the sample from
            // the live frame rather than the shift register.
            w_state_nxt  = S_QUIET;
            w_cs_n_nxt   = 1'b1;
            w_sclk_nxt   = 1'b1;
            w_div_nxt    = '0;
            w_bits_nxt   = '0;
            w_sample_nxt = to_sample(w_frame[11:0]);
            w_valid_nxt  = 1'b1;
            w_ferr_nxt   = |w_frame[15:12];
          end else begin
            w_bits_nxt = r_bits + 4'd1;
          end
        end
      end
      S_QUIET: begin
        if (r_div == QUIET_LAST) begin
          w_state_nxt = S_IDLE;
          w_busy_nxt  = 1'b0;
          w_div_nxt   = '0;
        end else begin
          w_div_nxt = r_div + 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // ---- control / output registers ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_div    <= '0;
      r_bits   <= '0;
      r_sclk   <= 1'b1;
      r_sclk_d <= 1'b1;
      r_cs_n   <= 1'b1;
      r_busy   <= 1'b0;
      r_sample <= '0;
      r_valid  <= 1'b0;
      r_ferr   <= 1'b0;
      r_missed <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_div    <= w_div_nxt;
      r_bits   <= w_bits_nxt;
      r_sclk   <= w_sclk_nxt;
      r_sclk_d <= r_sclk;
      r_cs_n   <= w_cs_n_nxt;
      r_busy   <= w_busy_nxt;
      r_sample <= w_sample_nxt;
      r_valid  <= w_valid_nxt;
      r_ferr   <= w_ferr_nxt;
      r_missed <= w_missed_nxt;
    end
  end

  // ---- serial shift register (data only, no reset needed) ----
  always_ff @(posedge clk) begin
    if (w_capture) begin
      r_shift <= w_frame[14:0];
    end
  end

  assign cs_n         = r_cs_n;
  assign sclk         = r_sclk;
  assign sample       = r_sample;
  assign sample_valid = r_valid;
  assign frame_err    = r_ferr;
  assign missed_tick  = r_missed;
  assign busy         = r_busy;

endmodule
